jt1943_objdma: RTL and testbench

- Object DMA controller for the 1943 main board.
- At each vertical blank it takes the main CPU work-RAM bus via the Z80 BUSRQ/BUSAK handshake.
- It copies the sprite table from work RAM into the object line buffer's source RAM, then returns the bus.
- It drives the main CPU block's bus_req, blcnten and obj_AB inputs, and consumes that block's bus_ack and ram_dout outputs.

---
 rtl/jt1943_objdma.sv | 106 ++++++++++
 tb/tb_jt1943_objdma.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_objdma.sv
// rtl/jt1943_objdma.sv - Object DMA: copies the sprite table from work RAM to the object buffer each vblank
module jt1943_objdma #(
  parameter int              AW       = 13,
  parameter logic [AW-1:0]   OBJ_BASE = 13'h1000,
  parameter int              OBJ_LEN  = 512,
  parameter int              BW       = 9
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic          blcnten,
  output logic [AW-1:0] obj_AB,
  input  logic [7:0]    ram_dout,
  output logic          buf_we,
  output logic [BW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          busy,
  output logic          missed
);

  typedef enum logic [2:0] {IDLE, REQ, COPY, DRAIN, RELEASE} state_t;

  localparam logic [BW-1:0] LAST = BW'(OBJ_LEN-1);

  state_t        state, state_nxt;
  logic [BW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] ab_nxt;
  logic          lvbl_l;
  logic          trigger;
  logic          wr_phase;

  assign trigger = lvbl_l & ~LVBL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      obj_AB <= '0;
      lvbl_l <= 1'b1;
    end else if (cen) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      obj_AB <= ab_nxt;
      lvbl_l <= LVBL;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ab_nxt    = obj_AB;
    bus_req   = 1'b0;
    blcnten   = 1'b0;
    busy      = 1'b0;
    missed    = 1'b0;
    wr_phase  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_ack) begin
          state_nxt = COPY;
          ab_nxt    = OBJ_BASE;
          cnt_nxt   = '0;
        end else if (LVBL) begin
          missed    = cen;
          state_nxt = IDLE;
        end
      end
      COPY: begin
        bus_req  = 1'b1;
        blcnten  = 1'b1;
        busy     = 1'b1;
        // RAM data trails the address by one cen, so the write lags the read by one byte
        wr_phase = (cnt != '0);
        ab_nxt   = OBJ_BASE + AW'(cnt) + AW'(1);
        cnt_nxt  = cnt + BW'(1);
        if (cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus_req   = 1'b1;
        blcnten   = 1'b1;
        busy      = 1'b1;
        wr_phase  = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        busy = 1'b1;
        if (!bus_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt has wrapped to zero in DRAIN, so cnt-1 addresses the last byte
  assign buf_we   = wr_phase & cen;
  assign buf_addr = wr_phase ? cnt - BW'(1) : '0;
  assign buf_din  = wr_phase ? ram_dout : 8'd0;

endmodule

// File: tb/tb_jt1943_objdma.sv
// tb/tb_jt1943_objdma.sv - Scoreboard bench for the object DMA with a Z80 bus agent and work-RAM model
module tb_jt1943_objdma;

  localparam int            AW       = 13;
  localparam int            BW       = 9;
  localparam int            OBJ_LEN  = 512;
  localparam logic [AW-1:0] OBJ_BASE = 13'h1000;

  logic          clk = 1'b0;
  logic          rst, cen, LVBL, bus_req, bus_ack, blcnten, buf_we, busy, missed;
  logic [AW-1:0] obj_AB;
  logic [7:0]    ram_dout, buf_din;
  logic [BW-1:0] buf_addr;

  logic [7:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [BW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  wr_t exp_q[$];
  wr_t e;

  int   n_cmp = 0, n_bad = 0;
  int   rate = 1, div = 0;
  int   ack_delay = 3, rel_delay = 0;
  logic ack_hold = 1'b0;
  int   writes = 0, missed_cnt = 0;
  logic cen_last = 1'b0, rst_last = 1'b1;
  logic granted = 1'b0;
  int   gcnt = 0;
  logic [AW+2:0] snap = '0;

  jt1943_objdma dut (
    .clk(clk), .rst(rst), .cen(cen), .LVBL(LVBL),
    .bus_req(bus_req), .bus_ack(bus_ack), .blcnten(blcnten),
    .obj_AB(obj_AB), .ram_dout(ram_dout),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
    .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns 2 time units after the next clk edge on which cen was high
  task automatic tick();
    forever begin
      @(posedge clk);
      if (cen) break;
    end
    #2;
  endtask

  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1 >= rate) ? 0 : div + 1;
      cen = (div == 0);
    end
  end

  // Work RAM with one-cen registered read
  always @(posedge clk) if (cen) ram_dout <= mem[obj_AB];

  always @(posedge clk) begin
    cen_last = cen;
    rst_last = rst;
  end

  // Z80 BUSRQ/BUSAK agent
  initial begin
    int rc, lc;
    rc = 0; lc = 0;
    bus_ack = 1'b0;
    forever begin
      tick();
      if (bus_req && !bus_ack && !ack_hold) begin
        rc++;
        if (rc >= ack_delay) begin bus_ack = 1'b1; rc = 0; end
      end else if (!bus_req) begin
        rc = 0;
        if (bus_ack) begin
          if (lc >= rel_delay) begin bus_ack = 1'b0; lc = 0; end
          else lc++;
        end
      end
    end
  end

  // Monitor: scoreboard pops, cen alignment, hold between cens, grant-to-release length
  always @(negedge clk) begin
    if (buf_we) begin
      check("buf_we on cen", cen, 1);
      writes++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra write: got addr %0h expected no write", buf_addr);
      end else begin
        e = exp_q.pop_front();
        check("buf_addr", buf_addr, e.a);
        check("buf_din", buf_din, e.d);
      end
    end
    if (missed) begin
      check("missed on cen", cen, 1);
      if (cen) missed_cnt++;
    end
    if (blcnten) check("blcnten needs bus_ack", bus_ack, 1);
    if (!cen_last && !rst_last)
      check("hold between cens", {obj_AB, bus_req, blcnten, busy}, snap);
    snap = {obj_AB, bus_req, blcnten, busy};
    if (rst) granted = 1'b0;
    else if (!granted) begin
      if (cen && bus_req && bus_ack && !blcnten) begin granted = 1'b1; gcnt = 0; end
    end else if (!bus_req) begin
      check("grant to release cens", gcnt, OBJ_LEN + 1);
      granted = 1'b0;
    end else if (cen) gcnt++;
  end

  task automatic start_xfer(input string tag);
    int t;
    for (int i = 0; i < OBJ_LEN; i++)
      exp_q.push_back('{BW'(i), mem[OBJ_BASE + AW'(i)]});
    writes = 0;
    LVBL = 1'b0;
    t = 0;
    while (!busy && t < 50) begin tick(); t++; end
    check({tag, " started"}, busy, 1);
  endtask

  task automatic finish_xfer(input string tag);
    int t;
    t = 0;
    while (busy && t < 2000) begin tick(); t++; end
    check({tag, " busy done"}, busy, 0);
    check({tag, " writes"}, writes, OBJ_LEN);
    check({tag, " queue empty"}, exp_q.size(), 0);
    exp_q.delete();
    LVBL = 1'b1;
    repeat (3) tick();
  endtask

  task automatic fill_random();
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    int t, m0, held;
    logic [AW-1:0] ad;
    rst = 1'b1;
    LVBL = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst bus_req", bus_req, 0);
    check("rst blcnten", blcnten, 0);
    check("rst obj_AB", obj_AB, 0);
    check("rst buf_we", buf_we, 0);
    check("rst buf_addr", buf_addr, 0);
    check("rst buf_din", buf_din, 0);
    check("rst busy", busy, 0);
    check("rst missed", missed, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Basic transfer with the addr^0x5A pattern
    for (int a = 0; a < (1 << AW); a++) begin
      ad = AW'(a);
      mem[a] = ad[7:0] ^ 8'h5A;
    end
    start_xfer("basic");
    finish_xfer("basic");

    // Missed vblank: grant never arrives
    ack_hold = 1'b1;
    m0 = missed_cnt;
    writes = 0;
    LVBL = 1'b0;
    repeat (20) tick();
    check("missed req up", bus_req, 1);
    LVBL = 1'b1;
    repeat (5) tick();
    check("missed pulses", missed_cnt - m0, 1);
    check("missed bus_req", bus_req, 0);
    check("missed busy", busy, 0);
    check("missed writes", writes, 0);
    ack_hold = 1'b0;
    fill_random();
    start_xfer("after miss");
    finish_xfer("after miss");

    // LVBL glitch during the copy is ignored
    fill_random();
    start_xfer("retrigger");
    t = 0;
    while (writes < 100 && t < 5000) begin @(negedge clk); t++; end
    LVBL = 1'b1;
    repeat (2) tick();
    LVBL = 1'b0;
    finish_xfer("retrigger");

    // Reset in the middle of a copy
    fill_random();
    start_xfer("reset");
    t = 0;
    while (writes < 100 && t < 5000) begin @(negedge clk); t++; end
    check("reset reached byte 100", writes >= 100, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    LVBL = 1'b1;
    @(posedge clk);
    #1;
    check("reset bus_req", bus_req, 0);
    check("reset blcnten", blcnten, 0);
    check("reset busy", busy, 0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (20) tick();
    check("reset ack released", bus_ack, 0);
    start_xfer("after reset");
    finish_xfer("after reset");

    // Slow bus release
    rel_delay = 10;
    fill_random();
    start_xfer("slow");
    t = 0;
    while (bus_req && t < 2000) begin tick(); t++; end
    held = 0;
    while (bus_ack && held < 100) begin
      check("slow busy", busy, 1);
      check("slow blcnten", blcnten, 0);
      tick();
      held++;
    end
    check("slow hold length", held >= 10, 1);
    finish_xfer("slow");
    rel_delay = 0;

    // cen at 1/8 of clk
    rate = 8;
    fill_random();
    start_xfer("cen8");
    finish_xfer("cen8");
    rate = 1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
